// File: rtl/store_buffer_if.sv
// Request/response memory port shared by the CPU side and the dcache side of the store buffer.
interface store_buffer_if;
    logic        read;
    logic        write;
    logic [3:0]  mbe;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;

    modport master (
        output read, write, mbe, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, mbe, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: stores are acked on enqueue and drained to the dcache in FIFO order;
// loads bypass the queue unless a queued store targets the same word, in which case the queue drains first.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    store_buffer_if.slave  cpu,
    store_buffer_if.master dcache,
    output logic           sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, RESP} state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      entry_addr [DEPTH];
    logic [3:0]       entry_mbe  [DEPTH];
    logic [31:0]      entry_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic        store_ack;
    logic [31:0] rdata_q;
    logic        resp;
    logic        push;
    logic        pop;
    logic        load_match;

    assign resp      = store_ack | (state == RESP);
    assign cpu.resp  = resp;
    assign cpu.rdata = rdata_q;

    // A held store is not re-accepted while its own ack is on the bus.
    assign push = cpu.write && (count < FULL_COUNT) && !resp;

    always_comb begin
        load_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i][31:2] == cpu.address[31:2])) begin
                load_match = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu.read && !load_match) begin
                    state_next = LOAD;
                end else if (count != '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (dcache.resp) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            LOAD: begin
                if (dcache.resp) begin
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dcache.read    = 1'b0;
        dcache.write   = 1'b0;
        dcache.mbe     = 4'h0;
        dcache.address = 32'h0;
        dcache.wdata   = 32'h0;
        if (state == DRAIN) begin
            dcache.write   = 1'b1;
            dcache.mbe     = entry_mbe[head];
            dcache.address = entry_addr[head];
            dcache.wdata   = entry_data[head];
        end else if (state == LOAD) begin
            dcache.read    = 1'b1;
            dcache.address = cpu.address;
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
            store_ack   <= 1'b0;
            rdata_q     <= 32'h0;
            sb_empty    <= 1'b1;
        end else begin
            state     <= state_next;
            count     <= count_next;
            sb_empty  <= (count_next == '0);
            store_ack <= push;
            if (push) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (state == LOAD && dcache.resp) begin
                rdata_q <= dcache.rdata;
            end
        end
    end

    // Entry payload needs no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail] <= cpu.address;
            entry_mbe[tail]  <= cpu.mbe;
            entry_data[tail] <= cpu.wdata;
        end
    end

endmodule
